// File: rtl/dpe_dest_demux.sv
// Routes ingress frames to CPU/ETH_1..ETH_4 by the DPE address on the first beat; 7 broadcasts.
// Optional DPE_DEMUX_DROP_CNT_EN adds a saturating count of frames dropped for dest 5/6.
//
// state | meaning
// IDLE  | next accepted beat is the first beat of a frame
// FWD   | frame in progress, routing mask latched
// DROP  | discarding a frame with an invalid destination
module dpe_dest_demux #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_last,
   input  logic [2:0]    s_dest,
   output logic [4:0]    m_valid,
   input  logic [4:0]    m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last
`ifdef DPE_DEMUX_DROP_CNT_EN
   ,
   output logic [15:0]   drop_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

   state_t     state;
   logic [4:0] pend;
   logic [4:0] mask;
   logic [4:0] dest_mask;
   logic       dest_valid;
   logic       accept;
   logic       drop_first;

   always_comb begin
      dest_mask = 5'b00000;
      case (s_dest)
         3'd0:    dest_mask = 5'b00001;
         3'd1:    dest_mask = 5'b00010;
         3'd2:    dest_mask = 5'b00100;
         3'd3:    dest_mask = 5'b01000;
         3'd4:    dest_mask = 5'b10000;
         3'd7:    dest_mask = 5'b11111;
         default: dest_mask = 5'b00000;
      endcase
   end

   assign dest_valid = (dest_mask != 5'b00000);

   // Ready when every still-pending port drains this cycle; rst_n gates it low during reset.
   assign s_ready    = rst_n & ((state == DROP) || ((pend & ~m_ready) == 5'b00000));
   assign accept     = s_valid & s_ready;
   assign drop_first = accept & (state == IDLE) & ~dest_valid;
   assign m_valid    = pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pend   <= 5'b00000;
         mask   <= 5'b00000;
         m_data <= '0;
         m_last <= 1'b0;
      end else begin
         pend <= pend & ~m_ready;
         if (accept) begin
            case (state)
               IDLE: begin
                  if (dest_valid) begin
                     pend   <= dest_mask;
                     mask   <= dest_mask;
                     m_data <= s_data;
                     m_last <= s_last;
                     state  <= s_last ? IDLE : FWD;
                  end else begin
                     state  <= s_last ? IDLE : DROP;
                  end
               end
               FWD: begin
                  pend   <= mask;
                  m_data <= s_data;
                  m_last <= s_last;
                  if (s_last) state <= IDLE;
               end
               DROP: begin
                  if (s_last) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef DPE_DEMUX_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= 16'h0000;
      end else if (drop_first && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'h0001;
      end
   end
`else
   logic unused_drop;
   assign unused_drop = drop_first;
`endif

endmodule

// File: tb/tb_dpe_dest_demux.sv
// Directed bench for dpe_dest_demux: unicast, broadcast skew, invalid dest, throughput, reset.
module tb_dpe_dest_demux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic [2:0]  s_dest;
   logic [4:0]  m_valid;
   logic [4:0]  m_ready;
   logic [31:0] m_data;
   logic        m_last;
`ifdef DPE_DEMUX_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   dpe_dest_demux #(.DW(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .s_dest  (s_dest),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
`ifdef DPE_DEMUX_DROP_CNT_EN
      ,
      .drop_cnt(drop_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic l,
                        input logic [2:0] dest, input logic [4:0] mr);
      s_valid = v;
      s_data  = d;
      s_last  = l;
      s_dest  = dest;
      m_ready = mr;
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic [4:0] v, input logic [31:0] d,
                          input logic l);
      chk({tag, "_valid"}, {27'b0, m_valid}, {27'b0, v});
      chk({tag, "_data"}, m_data, d);
      chk({tag, "_last"}, {31'b0, m_last}, {31'b0, l});
   endtask

   logic [2:0] tp_dest [8];

   initial begin
      tp_dest = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 3'd0, 5'b11111);
      #2;
      chk("rst_ready", {31'b0, s_ready}, 32'd0);
      chk_out("rst", 5'b00000, 32'h0, 1'b0);
`ifdef DPE_DEMUX_DROP_CNT_EN
      chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
`endif
      tick; tick;
      rst_n = 1'b1;
      #1 chk("post_rst_ready", {31'b0, s_ready}, 32'd1);

      // Unicast to ETH_2
      tick;
      drive(1'b1, 32'hA0, 1'b0, 3'd2, 5'b11111);
      #1 chk("uni_ready", {31'b0, s_ready}, 32'd1);
      tick; chk_out("uni0", 5'b00100, 32'hA0, 1'b0);
      drive(1'b1, 32'hA1, 1'b0, 3'd2, 5'b11111);
      tick; chk_out("uni1", 5'b00100, 32'hA1, 1'b0);
      drive(1'b1, 32'hA2, 1'b1, 3'd2, 5'b11111);
      tick; chk_out("uni2", 5'b00100, 32'hA2, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 3'd0, 5'b11111);
      tick; chk("uni_idle", {27'b0, m_valid}, 32'd0);

      // Broadcast with ETH_3 stalled for four cycles
      drive(1'b1, 32'hB0, 1'b0, 3'd7, 5'b10111);
      tick; chk_out("bc0", 5'b11111, 32'hB0, 1'b0);
      drive(1'b1, 32'hB1, 1'b1, 3'd0, 5'b10111);
      #1 chk("bc_stall_rdy0", {31'b0, s_ready}, 32'd0);
      tick; chk_out("bc0_skew1", 5'b01000, 32'hB0, 1'b0);
      #1 chk("bc_stall_rdy1", {31'b0, s_ready}, 32'd0);
      tick; chk_out("bc0_skew2", 5'b01000, 32'hB0, 1'b0);
      tick; chk_out("bc0_skew3", 5'b01000, 32'hB0, 1'b0);
      drive(1'b1, 32'hB1, 1'b1, 3'd0, 5'b11111);
      #1 chk("bc_release_rdy", {31'b0, s_ready}, 32'd1);
      tick; chk_out("bc1", 5'b11111, 32'hB1, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 3'd0, 5'b11111);
      tick; chk("bc_idle", {27'b0, m_valid}, 32'd0);

      // Invalid destination frame, then CPU frame
      drive(1'b1, 32'hC0, 1'b0, 3'd5, 5'b11111);
      #1 chk("inv_rdy0", {31'b0, s_ready}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         tick;
         chk("inv_valid", {27'b0, m_valid}, 32'd0);
         drive(1'b1, 32'hC0 + i, (i == 3), 3'd0, 5'b00000);
         #1 chk("inv_rdy", {31'b0, s_ready}, 32'd1);
      end
      tick; chk("inv_valid_end", {27'b0, m_valid}, 32'd0);
      drive(1'b1, 32'hD0, 1'b1, 3'd0, 5'b11111);
      tick; chk_out("cpu", 5'b00001, 32'hD0, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 3'd0, 5'b11111);
`ifdef DPE_DEMUX_DROP_CNT_EN
      chk("drop_cnt", {16'b0, drop_cnt}, 32'd1);
`endif
      tick; chk("cpu_idle", {27'b0, m_valid}, 32'd0);

      // Destination changes mid-frame are ignored
      drive(1'b1, 32'hE0, 1'b0, 3'd1, 5'b11111);
      tick; chk_out("mid0", 5'b00010, 32'hE0, 1'b0);
      drive(1'b1, 32'hE1, 1'b0, 3'd4, 5'b11111);
      tick; chk_out("mid1", 5'b00010, 32'hE1, 1'b0);
      drive(1'b1, 32'hE2, 1'b1, 3'd4, 5'b11111);
      tick; chk_out("mid2", 5'b00010, 32'hE2, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 3'd0, 5'b11111);
      tick;

      // Back-to-back single-beat frames
      for (int i = 0; i < 8; i++) begin
         if (i > 0) chk_out("tp", 5'b00001 << tp_dest[i-1], 32'h10 + i - 1, 1'b1);
         drive(1'b1, 32'h10 + i, 1'b1, tp_dest[i], 5'b11111);
         #1 chk("tp_ready", {31'b0, s_ready}, 32'd1);
         tick;
      end
      chk_out("tp_last", 5'b00100, 32'h17, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 3'd0, 5'b11111);
      tick;

      // Reset in the middle of a stalled frame
      drive(1'b1, 32'hF0, 1'b0, 3'd2, 5'b00000);
      tick; chk_out("mrst0", 5'b00100, 32'hF0, 1'b0);
      chk("mrst_stall", {31'b0, s_ready}, 32'd0);
      drive(1'b0, 32'h0, 1'b0, 3'd0, 5'b00000);
      #2 rst_n = 1'b0;
      #1 chk_out("mrst_clear", 5'b00000, 32'h0, 1'b0);
      tick;
      rst_n = 1'b1;
      drive(1'b1, 32'hF1, 1'b1, 3'd3, 5'b11111);
      #1 chk("mrst_rdy", {31'b0, s_ready}, 32'd1);
      tick; chk_out("mrst_new", 5'b01000, 32'hF1, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 3'd0, 5'b11111);
      tick; chk("mrst_idle", {27'b0, m_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
